// File: rtl/return_stack.sv
// Two-level PIC10F200 style return-address shift stack. On overflow the oldest entry is lost,
// and on pop the bottom entry is kept. Also reports occupancy and sticky overflow/underflow flags.
module return_stack #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stack_push,
  input  logic                       stack_pop,
  input  logic [WIDTH-1:0]           stack_in,
  input  logic                       stack_clr,
  output logic [WIDTH-1:0]           stack_out,
  output logic [$clog2(DEPTH+1)-1:0] stack_level,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic                       stack_ovf,
  output logic                       stack_unf
);
  localparam int LW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] entry_q, entry_d;
  logic [LW-1:0]               level_q, level_d;
  logic                        ovf_q, ovf_d, unf_q, unf_d;
  logic                        empty, full;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));

  always_comb begin
    entry_d = entry_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case ({stack_push, stack_pop})
      2'b10: begin
        for (int i = DEPTH-1; i > 0; i--) entry_d[i] = entry_q[i-1];
        entry_d[0] = stack_in;
        if (full) ovf_d = 1'b1;
        else      level_d = level_q + LW'(1);
      end
      2'b01: begin
        // The bottom entry is left in place, so repeated pops keep returning it.
        for (int i = 0; i < DEPTH-1; i++) entry_d[i] = entry_q[i+1];
        if (empty) unf_d = 1'b1;
        else       level_d = level_q - LW'(1);
      end
      2'b11: begin
        entry_d[0] = stack_in;
        if (empty) unf_d = 1'b1;
      end
      default: ;
    endcase
    if (stack_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign stack_out   = entry_q[0];
  assign stack_level = level_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;
endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack. Expected values are worked out by hand
// for the default WIDTH=9 and DEPTH=2.
module tb_return_stack;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       stack_push, stack_pop, stack_clr;
  logic [8:0] stack_in;
  logic [8:0] stack_out;
  logic [1:0] stack_level;
  logic       stack_empty, stack_full, stack_ovf, stack_unf;

  int checks = 0;
  int errors = 0;

  return_stack #(.WIDTH(9), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .stack_push(stack_push), .stack_pop(stack_pop),
    .stack_in(stack_in), .stack_clr(stack_clr),
    .stack_out(stack_out), .stack_level(stack_level),
    .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic cyc(input logic rn, input logic ps, input logic pp, input logic cl,
                     input logic [8:0] d);
    rst_n = rn; stack_push = ps; stack_pop = pp; stack_clr = cl; stack_in = d;
    @(posedge clk);
    #1;
    rst_n = 1'b1; stack_push = 1'b0; stack_pop = 1'b0; stack_clr = 1'b0;
  endtask

  task automatic push(input logic [8:0] d); cyc(1'b1, 1'b1, 1'b0, 1'b0, d); endtask
  task automatic pop();                     cyc(1'b1, 1'b0, 1'b1, 1'b0, 9'h0); endtask
  task automatic rst();                     cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'h1FF); endtask

  initial begin
    rst_n = 1'b0; stack_push = 1'b1; stack_pop = 1'b0; stack_clr = 1'b0; stack_in = 9'h1FF;
    @(posedge clk);
    #1;
    rst_n = 1'b1; stack_push = 1'b0;
    chk("rst_out",   16'(stack_out),   16'h000);
    chk("rst_level", 16'(stack_level), 16'd0);
    chk("rst_empty", 16'(stack_empty), 16'd1);
    chk("rst_full",  16'(stack_full),  16'd0);
    chk("rst_ovf",   16'(stack_ovf),   16'd0);
    chk("rst_unf",   16'(stack_unf),   16'd0);

    // Basic push and pop
    push(9'h026);
    chk("p1_out",   16'(stack_out),   16'h026);
    chk("p1_level", 16'(stack_level), 16'd1);
    push(9'h0A1);
    chk("p2_out",   16'(stack_out),   16'h0A1);
    chk("p2_level", 16'(stack_level), 16'd2);
    chk("p2_full",  16'(stack_full),  16'd1);
    chk("p2_empty", 16'(stack_empty), 16'd0);
    pop();
    chk("q1_out",   16'(stack_out),   16'h026);
    chk("q1_level", 16'(stack_level), 16'd1);
    chk("q1_full",  16'(stack_full),  16'd0);
    pop();
    chk("q2_level", 16'(stack_level), 16'd0);
    chk("q2_empty", 16'(stack_empty), 16'd1);
    chk("q2_out",   16'(stack_out),   16'h026);
    chk("q2_unf",   16'(stack_unf),   16'd0);

    // Overflow drops the oldest entry
    push(9'h026); push(9'h0A1); push(9'h133);
    chk("ov_out",   16'(stack_out),   16'h133);
    chk("ov_level", 16'(stack_level), 16'd2);
    chk("ov_flag",  16'(stack_ovf),   16'd1);
    pop();
    chk("ov_q1_out",   16'(stack_out),   16'h0A1);
    chk("ov_q1_level", 16'(stack_level), 16'd1);
    pop();
    chk("ov_q2_out",   16'(stack_out),   16'h0A1);
    chk("ov_q2_level", 16'(stack_level), 16'd0);
    chk("ov_sticky",   16'(stack_ovf),   16'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 9'h0);
    chk("ov_clr",       16'(stack_ovf),   16'd0);
    chk("ov_clr_level", 16'(stack_level), 16'd0);

    // Underflow from empty after reset
    rst();
    pop();
    chk("un_flag",  16'(stack_unf),   16'd1);
    chk("un_level", 16'(stack_level), 16'd0);
    chk("un_out",   16'(stack_out),   16'h000);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 9'h0);
    chk("un_clr", 16'(stack_unf), 16'd0);
    // A clear in the same cycle beats the set
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 9'h0);
    chk("un_clr_prio", 16'(stack_unf),   16'd0);
    chk("un_clr_lvl",  16'(stack_level), 16'd0);

    // Push and pop together replace the top entry
    push(9'h010); push(9'h055);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 9'h0FE);
    chk("rp_out",   16'(stack_out),   16'h0FE);
    chk("rp_level", 16'(stack_level), 16'd2);
    chk("rp_ovf",   16'(stack_ovf),   16'd0);
    chk("rp_unf",   16'(stack_unf),   16'd0);
    pop();
    chk("rp_below", 16'(stack_out), 16'h010);

    // Push and pop together on an empty stack
    rst();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 9'h0AA);
    chk("rpe_out",   16'(stack_out),   16'h0AA);
    chk("rpe_level", 16'(stack_level), 16'd0);
    chk("rpe_unf",   16'(stack_unf),   16'd1);
    chk("rpe_ovf",   16'(stack_ovf),   16'd0);

    // Reset in the middle of operation
    rst();
    push(9'h026); push(9'h0A1); push(9'h133);
    chk("mr_pre_ovf", 16'(stack_ovf), 16'd1);
    rst();
    chk("mr_out",   16'(stack_out),   16'h000);
    chk("mr_level", 16'(stack_level), 16'd0);
    chk("mr_ovf",   16'(stack_ovf),   16'd0);
    chk("mr_unf",   16'(stack_unf),   16'd0);
    chk("mr_empty", 16'(stack_empty), 16'd1);
    pop();
    chk("mr_e1", 16'(stack_out), 16'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
